cache_ctrl_4way: RTL
====================

Name: cache_ctrl_4way

Overview:
- Control FSM for the 4-way set-associative cache.
- Sequences the per-set LRU stack (update on every serviced access; victim is the LRU way), the way/line datapath (word write, line fill, dirty bits) and the physical-memory port (writeback, allocate).
- Sits between the CPU memory interface and pmem. Tag compare and data arrays live in the datapath; this block only consumes hit/dirty status and drives control.

Parameters:
- WAYS, 4, number of ways. Fixed at 4 (matches the 2-bit LRU stack encoding); any other value is unsupported.
- CNT_W, 16, width of the optional performance counters.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_resp  out  1  1-cycle done pulse to CPU
- hit  in  4  per-way tag match AND valid for the indexed set, from datapath
- dirty  in  4  per-way dirty bits of the indexed set
- lru_way  in  2  LRU way of the indexed set (LRU stack output)
- lru_write  out  1  LRU stack update strobe
- lru_in  out  2  way just used; becomes MRU
- way_sel  out  2  way selected for datapath read/write muxing
- load_word  out  1  write CPU data into way_sel, masked by CPU byte enables
- load_line  out  1  write pmem line into way_sel; sets valid and tag
- set_dirty  out  1  set dirty[way_sel]
- clr_dirty  out  1  clear dirty[way_sel]
- addr_sel  out  1  pmem address: 0 = CPU address, 1 = victim tag + index
- pmem_read  out  1  physical-memory line read, held until pmem_resp
- pmem_write  out  1  physical-memory line write, held until pmem_resp
- pmem_resp  in  1  physical-memory done
- hit_count  out  CNT_W  optional counter
- miss_count  out  CNT_W  optional counter

Behaviour:
- States: IDLE, WRITEBACK, ALLOCATE. Reset → IDLE. Internal victim reg = 0.
- Outputs at reset and by default each cycle: all 0.
- Request: req = mem_read | mem_write. If both are asserted (illegal), treat as a write.
- Hit way: hit is one-hot. If several bits are set (illegal), the lowest index wins.
- IDLE, req & |hit (hit path, 0-cycle latency, same cycle):
  - mem_resp = 1, lru_write = 1, lru_in = hit way, way_sel = hit way.
  - Write: load_word = 1 and set_dirty = 1.
  - Stay in IDLE.
- IDLE, req & ~|hit (miss):
  - victim <= lru_way; no other outputs asserted.
  - Next state: WRITEBACK if dirty[lru_way], else ALLOCATE.
  - LRU is not updated on a miss.
- WRITEBACK:
  - way_sel = victim, addr_sel = 1, pmem_write = 1.
  - On pmem_resp → ALLOCATE.
- ALLOCATE:
  - way_sel = victim, addr_sel = 0, pmem_read = 1.
  - On pmem_resp, same cycle: load_line = 1 and clr_dirty = 1; then → IDLE.
  - The retried request then hits in IDLE, which performs the LRU update and mem_resp.
  - Miss latency = writeback cycles + fill cycles + 2 (miss cycle, hit cycle).
- IDLE, no req: idle. pmem_resp outside WRITEBACK/ALLOCATE is ignored.
- CPU drops its request mid-miss: the pmem transaction in flight still completes (no abort). ALLOCATE still fills, then IDLE, no mem_resp.
- victim is held constant from the miss cycle until the return to IDLE, even if lru_way changes.
- rst in any state, including mid-pmem transaction: IDLE next cycle, all outputs 0 that cycle. The pmem side must be reset by the same rst.
- The lru_write/lru_in contract matches the LRU stack: lru_in moves to MRU; lru_way reports the LRU way.

Optional Feature:
- Macro: CACHE_PERF_CNT_EN.
- Defined:
  - hit_count increments on each IDLE hit that is not the retry of a just-filled miss. A "filled" flag is set on the ALLOCATE completion and cleared on the next mem_resp.
  - miss_count increments on each IDLE miss cycle.
  - Both are CNT_W wide, saturate at all-ones, and reset to 0 on rst.
- Undefined: hit_count and miss_count are tied to 0; no counter or flag logic is present.

Test Plan:
- Reset, then idle 5 cycles → all outputs 0, state IDLE, counters 0.
- Read with hit=4'b0100 → same cycle: mem_resp=1, lru_write=1, lru_in=2, way_sel=2, load_word=0; hit_count=1 next cycle.
- Write with hit=4'b0000, lru_way=1, dirty=4'b0010:
  - Next cycle: WRITEBACK with pmem_write=1, addr_sel=1, way_sel=1.
  - pmem_resp after 3 cycles → ALLOCATE with pmem_read=1, addr_sel=0.
  - pmem_resp → load_line=1, clr_dirty=1.
  - Then hit=4'b0010 → mem_resp with load_word=1, set_dirty=1, lru_in=1.
  - Counters: miss_count=1, hit_count unchanged.
- Read miss with clean victim: lru_way=3, dirty=0 → ALLOCATE directly, no pmem_write ever asserted; lru_way changed to 0 during ALLOCATE → way_sel stays 3.
- rst asserted 2 cycles into WRITEBACK → next cycle IDLE, pmem_write=0; a fresh miss restarts cleanly.
- With CACHE_PERF_CNT_EN and CNT_W=4: 20 hits → hit_count holds 4'hF.

Source files
------------

// File: rtl/cache_ctrl_4way.sv
// Control FSM for a 4-way set-associative cache: hit servicing, LRU update, writeback and allocate.
// Optional performance counters are built when CACHE_PERF_CNT_EN is defined.
module cache_ctrl_4way #(
  parameter int WAYS  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic [WAYS-1:0]  hit,
  input  logic [WAYS-1:0]  dirty,
  input  logic [1:0]       lru_way,
  output logic             lru_write,
  output logic [1:0]       lru_in,
  output logic [1:0]       way_sel,
  output logic             load_word,
  output logic             load_line,
  output logic             set_dirty,
  output logic             clr_dirty,
  output logic             addr_sel,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

  state_e     state_q, state_d;
  logic [1:0] victim_q, victim_d;
  logic [1:0] hit_way;
  logic       req, any_hit;

  assign req     = mem_read | mem_write;
  assign any_hit = |hit;

  // Lowest-index hit wins if the datapath ever reports more than one.
  always_comb begin
    hit_way = '0;
    for (int i = WAYS - 1; i >= 0; i--)
      if (hit[i]) hit_way = 2'(i);
  end

  always_comb begin
    state_d    = state_q;
    victim_d   = victim_q;
    mem_resp   = 1'b0;
    lru_write  = 1'b0;
    lru_in     = '0;
    way_sel    = '0;
    load_word  = 1'b0;
    load_line  = 1'b0;
    set_dirty  = 1'b0;
    clr_dirty  = 1'b0;
    addr_sel   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (req && any_hit) begin
            mem_resp  = 1'b1;
            lru_write = 1'b1;
            lru_in    = hit_way;
            way_sel   = hit_way;
            load_word = mem_write;
            set_dirty = mem_write;
          end else if (req) begin
            victim_d = lru_way;
            state_d  = dirty[lru_way] ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          way_sel    = victim_q;
          addr_sel   = 1'b1;
          pmem_write = 1'b1;
          if (pmem_resp) state_d = ALLOCATE;
        end
        ALLOCATE: begin
          way_sel   = victim_q;
          pmem_read = 1'b1;
          // Fill completes here; the CPU retry then hits in IDLE and takes the LRU update.
          if (pmem_resp) begin
            load_line = 1'b1;
            clr_dirty = 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic             filled_q, filled_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // The retry hit following a fill is part of the miss and is not counted as a hit.
  always_comb begin
    filled_d   = filled_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == IDLE && req && any_hit && !filled_q && !(&hit_cnt_q))
      hit_cnt_d = hit_cnt_q + 1'b1;
    if (state_q == IDLE && req && !any_hit && !(&miss_cnt_q))
      miss_cnt_d = miss_cnt_q + 1'b1;
    if (state_q == ALLOCATE && pmem_resp) filled_d = 1'b1;
    else if (mem_resp)                    filled_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filled_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      filled_q   <= filled_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule
